// File: rtl/fg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fg_pkg
// Brief    : Shared widths, FSM states and Mode-to-period table for the
//            waveform sample sequencer.
// Revision : 1.0
// ============================================================================
package fg_pkg;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 14;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_P0   = 3'd1,
      ST_P1   = 3'd2,
      ST_P2   = 3'd3,
      ST_RUN  = 3'd4
   } fg_state_t;

   localparam int unsigned C_PERIOD_TBL [5] = '{1, 10, 100, 1000, 10000};

   // Segment length in Fg_clk cycles; reserved Mode codes fall back to 1.
   function automatic int unsigned fg_period(input logic [2:0] mode);
      case (mode)
         3'd0:    fg_period = C_PERIOD_TBL[0];
         3'd1:    fg_period = C_PERIOD_TBL[1];
         3'd2:    fg_period = C_PERIOD_TBL[2];
         3'd3:    fg_period = C_PERIOD_TBL[3];
         3'd4:    fg_period = C_PERIOD_TBL[4];
         default: fg_period = 1;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/fg_segment_timer.sv
`default_nettype none
// ============================================================================
// Module   : fg_segment_timer
// Brief    : Per-segment down-counter; Mode is decoded at each segment end
//            and the counter reloaded with N-1.
// Revision : 1.0
// ============================================================================
module fg_segment_timer #(
   parameter int CNT_W = fg_pkg::CNT_W
) (
   input  logic       Fg_clk,
   input  logic       Resetn,
   input  logic [2:0] i_mode,
   input  logic       i_clear,
   input  logic       i_load,
   input  logic       i_count,
   output logic       o_terminal
);
   import fg_pkg::*;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_reload;

   // Mode is sampled only here, so a change mid-segment waits for the next end.
   assign w_reload   = CNT_W'(fg_period(i_mode) - 1);
   assign o_terminal = i_count && (r_cnt == '0);

   always_ff @(posedge Fg_clk or negedge Resetn) begin
      if (!Resetn) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= w_reload;
      end else if (i_count && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fg_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fg_sample_sequencer
// Brief    : Loops over the sample RAM and feeds (current, next) sample pairs
//            to the interpolator with an Enable strobe every 10^Mode cycles.
// Revision : 1.0
// ============================================================================
module fg_sample_sequencer #(
   parameter int ADDR_W = fg_pkg::ADDR_W,
   parameter int DATA_W = fg_pkg::DATA_W,
   parameter int CNT_W  = fg_pkg::CNT_W
) (
   input  logic              Fg_clk,
   input  logic              Resetn,
   input  logic              i_Run,
   input  logic [2:0]        i_Mode,
   input  logic [ADDR_W-1:0] i_Length,
   output logic              o_Mem_rd,
   output logic [ADDR_W-1:0] o_Mem_addr,
   input  logic [DATA_W-1:0] i_Mem_data,
   output logic [DATA_W-1:0] o_Out1,
   output logic [DATA_W-1:0] o_Out2,
   output logic              o_Enable,
   output logic              o_Wrap,
   output logic              o_Busy
);
   import fg_pkg::*;

   fg_state_t         r_state;
   fg_state_t         w_next;
   logic [ADDR_W-1:0] r_len;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              w_mem_rd;
   logic              w_terminal;
   logic              w_seg_end;
   logic              r_rd_d;
   logic              r_rd_z_d;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_z;
   logic [DATA_W-1:0] r_out1;
   logic [DATA_W-1:0] r_out2;
   logic              r_out1_z;
   logic              r_enable;
   logic              r_wrap;

   fg_segment_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .Fg_clk     (Fg_clk),
      .Resetn     (Resetn),
      .i_mode     (i_Mode),
      .i_clear    (r_state == ST_IDLE),
      .i_load     (w_seg_end),
      .i_count    (r_state == ST_RUN),
      .o_terminal (w_terminal)
   );

   // P2 doubles as the terminal cycle of the first segment.
   assign w_seg_end  = (r_state == ST_P2) || ((r_state == ST_RUN) && w_terminal);
   assign w_addr_nxt = (r_addr == r_len) ? '0 : r_addr + 1'b1;

   always_comb begin
      w_next   = r_state;
      w_mem_rd = 1'b0;
      case (r_state)
         ST_IDLE: if (i_Run) w_next = ST_P0;
         ST_P0: begin
            w_mem_rd = 1'b1;
            w_next   = ST_P1;
         end
         ST_P1: begin
            w_mem_rd = 1'b1;
            w_next   = ST_P2;
         end
         ST_P2: begin
            w_mem_rd = 1'b1;
            w_next   = ST_RUN;
         end
         ST_RUN:  w_mem_rd = w_terminal;
         default: w_next = ST_IDLE;
      endcase
      if ((r_state != ST_IDLE) && !i_Run) w_next = ST_IDLE;
   end

   always_ff @(posedge Fg_clk or negedge Resetn) begin
      if (!Resetn) begin
         r_state  <= ST_IDLE;
         r_len    <= '0;
         r_addr   <= '0;
         r_rd_d   <= 1'b0;
         r_rd_z_d <= 1'b0;
         r_hold   <= '0;
         r_hold_z <= 1'b0;
         r_out1   <= '0;
         r_out2   <= '0;
         r_out1_z <= 1'b0;
         r_enable <= 1'b0;
         r_wrap   <= 1'b0;
      end else begin
         r_state  <= w_next;
         // A read still in flight when stopping is dropped here.
         r_rd_d   <= w_mem_rd && (w_next != ST_IDLE);
         r_rd_z_d <= (r_addr == '0);
         if (r_rd_d) begin
            r_hold   <= i_Mem_data;
            r_hold_z <= r_rd_z_d;
         end

         if (r_state == ST_IDLE) begin
            r_addr <= '0;
            if (i_Run) r_len <= (i_Length == '0) ? ADDR_W'(1) : i_Length;
         end else if (w_mem_rd) begin
            r_addr <= w_addr_nxt;
         end

         r_enable <= 1'b0;
         r_wrap   <= 1'b0;
         if (w_seg_end && i_Run) begin
            r_enable <= 1'b1;
            if (r_state == ST_P2) begin
               r_out2   <= r_hold;
               r_wrap   <= r_hold_z;
               r_out1   <= i_Mem_data;
               r_out1_z <= r_rd_z_d;
            end else begin
               // With N=1 the sample arrives in the terminal cycle itself.
               r_out2   <= r_out1;
               r_wrap   <= r_out1_z;
               r_out1   <= r_rd_d ? i_Mem_data : r_hold;
               r_out1_z <= r_rd_d ? r_rd_z_d : r_hold_z;
            end
         end
      end
   end

   assign o_Mem_rd   = w_mem_rd;
   assign o_Mem_addr = r_addr;
   assign o_Out1     = r_out1;
   assign o_Out2     = r_out2;
   assign o_Enable   = r_enable;
   assign o_Wrap     = r_wrap;
   assign o_Busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fg_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fg_sample_sequencer
// Brief    : Directed scoreboard bench for fg_sample_sequencer.
// Revision : 1.0
// ============================================================================
module tb_fg_sample_sequencer;

   logic        Fg_clk = 1'b0;
   logic        Resetn = 1'b1;
   logic        i_Run = 1'b0;
   logic [2:0]  i_Mode = 3'd0;
   logic [10:0] i_Length = 11'd0;
   logic        o_Mem_rd;
   logic [10:0] o_Mem_addr;
   logic [31:0] i_Mem_data;
   logic [31:0] o_Out1;
   logic [31:0] o_Out2;
   logic        o_Enable;
   logic        o_Wrap;
   logic        o_Busy;

   fg_sample_sequencer dut (
      .Fg_clk     (Fg_clk),
      .Resetn     (Resetn),
      .i_Run      (i_Run),
      .i_Mode     (i_Mode),
      .i_Length   (i_Length),
      .o_Mem_rd   (o_Mem_rd),
      .o_Mem_addr (o_Mem_addr),
      .i_Mem_data (i_Mem_data),
      .o_Out1     (o_Out1),
      .o_Out2     (o_Out2),
      .o_Enable   (o_Enable),
      .o_Wrap     (o_Wrap),
      .o_Busy     (o_Busy)
   );

   always #5 Fg_clk = ~Fg_clk;

   // Synchronous sample RAM: data appears the cycle after the read strobe.
   logic [31:0] mem [16];
   initial for (int i = 0; i < 16; i++) mem[i] = i * 32'h1000_0000;
   always @(posedge Fg_clk) if (o_Mem_rd) i_Mem_data <= mem[o_Mem_addr[3:0]];

   typedef struct {
      int          cyc;
      logic [31:0] o2;
      logic [31:0] o1;
      logic        w;
   } en_t;
   typedef struct {
      int          cyc;
      logic [10:0] addr;
   } rd_t;

   en_t q_en[$];
   rd_t q_rd[$];
   int  cyc = 0;
   int  base = 0;
   int  n_chk = 0;
   int  n_fail = 0;
   logic [31:0] last1 = '0;
   logic [31:0] last2 = '0;

   always @(posedge Fg_clk) cyc <= cyc + 1;

   function automatic logic [31:0] s(input int i);
      return i * 32'h1000_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc - base);
      end
   endtask

   task automatic exp_en(input int k, input int a, input int b, input logic w);
      en_t e;
      e.cyc = base + k; e.o2 = s(a); e.o1 = s(b); e.w = w;
      q_en.push_back(e);
   endtask

   task automatic exp_rd(input int k, input logic [10:0] addr);
      rd_t r;
      r.cyc = base + k; r.addr = addr;
      q_rd.push_back(r);
   endtask

   task automatic wait_to(input int k);
      while (cyc < base + k) @(negedge Fg_clk);
   endtask

   task automatic start(input logic [2:0] m, input logic [10:0] len);
      @(negedge Fg_clk);
      i_Mode   = m;
      i_Length = len;
      i_Run    = 1'b1;
      base     = cyc;
   endtask

   task automatic stop_at(input int k);
      wait_to(k);
      i_Run = 1'b0;
      wait_to(k + 1);
      check("busy_after_stop", o_Busy, 1'b0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT strobes Mem_rd or Enable.
   always @(negedge Fg_clk) begin
      if (!Resetn) begin
         check("rst_ctrl", {o_Mem_rd, o_Enable, o_Wrap, o_Busy}, 4'b0);
         check("rst_out1", o_Out1, 0);
         check("rst_out2", o_Out2, 0);
         check("rst_addr", o_Mem_addr, 0);
         last1 = '0;
         last2 = '0;
      end else begin
         if (o_Mem_rd) begin
            if (q_rd.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_rd: got addr %0d, want no read (cycle %0d)", o_Mem_addr, cyc - base);
            end else begin
               rd_t r;
               r = q_rd.pop_front();
               check("rd_cycle", cyc, r.cyc);
               check("rd_addr", o_Mem_addr, r.addr);
            end
         end
         if (o_Enable) begin
            if (q_en.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_enable: got Enable=1, want 0 (cycle %0d)", cyc - base);
            end else begin
               en_t e;
               e = q_en.pop_front();
               check("en_cycle", cyc, e.cyc);
               check("en_out2", o_Out2, e.o2);
               check("en_out1", o_Out1, e.o1);
               check("en_wrap", o_Wrap, e.w);
               last1 = e.o1;
               last2 = e.o2;
            end
         end else begin
            check("hold_out1", o_Out1, last1);
            check("hold_out2", o_Out2, last2);
            check("wrap_idle", o_Wrap, 1'b0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with Run high: everything stays at zero.
      i_Run = 1'b1;
      #1 Resetn = 1'b0;
      repeat (5) @(negedge Fg_clk);
      i_Run = 1'b0;
      #2 Resetn = 1'b1;
      repeat (3) @(negedge Fg_clk);
      check("idle_busy", o_Busy, 1'b0);

      // Mode 0, Length 3: new pair every cycle.
      start(3'd0, 11'd3);
      exp_rd(1, 0); exp_rd(2, 1); exp_rd(3, 2);
      exp_rd(4, 3); exp_rd(5, 0); exp_rd(6, 1); exp_rd(7, 2); exp_rd(8, 3);
      exp_en(4, 0, 1, 1); exp_en(5, 1, 2, 0); exp_en(6, 2, 3, 0);
      exp_en(7, 3, 0, 0); exp_en(8, 0, 1, 1);
      wait_to(1);
      check("busy_p0", o_Busy, 1'b1);
      stop_at(8);
      wait_to(12);

      // Mode 2: 100-cycle segments.
      start(3'd2, 11'd3);
      exp_rd(1, 0); exp_rd(2, 1); exp_rd(3, 2); exp_rd(103, 3); exp_rd(203, 0);
      exp_en(4, 0, 1, 1); exp_en(104, 1, 2, 0); exp_en(204, 2, 3, 0);
      stop_at(210);
      wait_to(214);

      // Mode 1 -> 2 mid-segment: current 10-cycle segment completes first.
      start(3'd1, 11'd3);
      exp_rd(1, 0); exp_rd(2, 1); exp_rd(3, 2); exp_rd(13, 3); exp_rd(113, 0);
      exp_en(4, 0, 1, 1); exp_en(14, 1, 2, 0); exp_en(114, 2, 3, 0);
      wait_to(6);
      i_Mode = 3'd2;
      stop_at(120);
      wait_to(124);

      // Stop at cycle 50, then restart from address 0.
      start(3'd2, 11'd3);
      exp_rd(1, 0); exp_rd(2, 1); exp_rd(3, 2);
      exp_en(4, 0, 1, 1);
      stop_at(50);
      wait_to(55);
      start(3'd2, 11'd3);
      exp_rd(1, 0); exp_rd(2, 1); exp_rd(3, 2);
      exp_en(4, 0, 1, 1);
      stop_at(10);
      wait_to(14);

      // Mode 7 acts as period 1; Length 0 forms a two-sample loop.
      start(3'd7, 11'd0);
      exp_rd(1, 0); exp_rd(2, 1); exp_rd(3, 0);
      exp_rd(4, 1); exp_rd(5, 0); exp_rd(6, 1); exp_rd(7, 0);
      exp_en(4, 0, 1, 1); exp_en(5, 1, 0, 0); exp_en(6, 0, 1, 1); exp_en(7, 1, 0, 0);
      stop_at(7);
      wait_to(11);

      // Reset pulse during P1.
      start(3'd0, 11'd3);
      exp_rd(1, 0); exp_rd(2, 1);
      wait_to(2);
      #2;
      Resetn = 1'b0;
      i_Run  = 1'b0;
      #1;
      check("midp1_busy", o_Busy, 1'b0);
      check("midp1_rd", o_Mem_rd, 1'b0);
      check("midp1_outs", {o_Out1, o_Out2}, 64'd0);
      repeat (2) @(negedge Fg_clk);
      #2 Resetn = 1'b1;
      repeat (20) @(negedge Fg_clk);

      check("en_queue_empty", q_en.size(), 0);
      check("rd_queue_empty", q_rd.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
